traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Independent safety monitor on the lamp outputs of the intersection controller. It samples the four car-lamp and four walk-lamp buses, detects conflicting greens, illegal lamp codes and illegal phase sequences, and raises a sticky fault with a diagnostic code. The fault output drives the board-level flash/override logic.

## Interface
Parameters:
- MIN_YELLOW, 3: minimum consecutive cycles a car lamp must hold yellow.
- FILTER_CYCLES, 2: persistence required for combinational faults when filtering is compiled in (range 1–15).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; one clock, synchronous, active-low.
- clear  in  1  synchronous pulse; clears latched fault state.
- car_traffic_0..3  in  4 each  car lamps, [3]=left arrow, [2]=green, [1]=yellow, [0]=red.
- walk_traffic_0..3  in  2 each  walk lamps, [1]=walk, [0]=don't-walk.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first-fault code (0 = none).
- fault_approach  out  2  approach index of the first fault.
- fault_count  out  8  violations seen since reset/clear, saturates at 255.

## Operation
- Approaches 0/2 form axis A; approaches 1/3 form axis B.
- Legal car codes: 0001 red, 0010 yellow, 0100 green, 1000 left, 1100 green+left. "Go" = any of green/left/yellow.
- Legal walk codes: 01 don't-walk, 10 walk.
- Stage 1: all inputs registered (cur); previous sample held in prev; valid flag set after the first post-reset sample.
- Fault codes, checked every cycle on cur, with prev where needed:
  - 1: car go on both axes simultaneously.
  - 2: walk on an approach while any car on the perpendicular axis is go.
  - 3: illegal car code (including all-dark).
  - 4: illegal walk code.
  - 5: car goes from green/left directly to red, skipping yellow.
  - 6: yellow→red after fewer than MIN_YELLOW yellow cycles.
  - 7: red→yellow or red→left/green→yellow order violations other than code 5. Specifically red→yellow, and yellow→green/left.
- Codes 5–7 require valid=1. The per-approach yellow counter counts consecutive cur=yellow cycles, saturates at MIN_YELLOW, and resets when cur≠yellow.
- Priority among simultaneous violations: lowest code, then lowest approach index. Codes 1/2 report the lowest approach index involved.
- The first violation latches fault=1, fault_code and fault_approach. Later violations only increment fault_count, by 1 per cycle with any violation.
- clear: zeroes fault, fault_code, fault_approach and fault_count. clear wins over a same-cycle violation. Sampling registers, counters and valid are not affected.
- Reset mid-operation: all state returns to reset values on the next edge. The valid flag drops.

## Timing
- Reset values: fault=0, fault_code=0, fault_approach=0, fault_count=0. Internally, valid=0 and yellow counters are 0.
- Latency: an offending value first present before edge k is sampled at k. fault, fault_code and fault_count update at edge k+1 (2-edge latency).
- Sequence faults use the prev/cur pair captured at edge k, with the same k+1 output timing.
- fault_count saturates: at 255 further violations leave it at 255.

## Configuration
- MONITOR_FILTER_EN defined: codes 1–4 need FILTER_CYCLES consecutive violating samples before they count or latch. A per-code persistence counter resets on any clean sample, so output latency is FILTER_CYCLES+1 edges. Codes 5–7 are unfiltered.
- Undefined: codes 1–4 act on a single sample, with no persistence counters.

## Test plan
- Legal cycle: car_traffic_0/2 take 0100 for 10 cycles, then 0010 for 3, then 0001; axis B is red, walks 01 → fault stays 0 and fault_code 0 throughout.
- Axis conflict: car_traffic_0=0100 and car_traffic_1=0100 for one cycle (filter off) → fault=1, code 1, approach 0 two edges later; fault_count=1. With MONITOR_FILTER_EN and FILTER_CYCLES=2, a 1-cycle glitch leaves fault=0.
- Short yellow: car_traffic_2 yellow for 2 cycles, then red (MIN_YELLOW=3) → code 6, approach 2. Green→red directly on approach 3 → code 5, approach 3.
- Simultaneous: car_traffic_1=0000 and walk_traffic_0=11 in the same cycle → code 3, approach 1. fault_count then increments per violating cycle and saturates at 255 after 300 cycles.
- Clear: pulse clear while a violation persists → outputs zero for one edge, then fault re-latches the next edge. Assert rstn=0 mid-fault → all outputs 0, and the first post-reset sample produces no sequence faults.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Independent safety watchdog on the intersection lamp buses. Flags conflicting
// greens, walk-versus-traffic conflicts, illegal lamp codes and illegal phase
// sequences, and latches the first fault with its code and approach.
// Build option: define MONITOR_FILTER_EN to require FILTER_CYCLES consecutive
// violating samples before codes 1-4 count or latch.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW    = 3,
    parameter int FILTER_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic [3:0] car_traffic_0,
    input  logic [3:0] car_traffic_1,
    input  logic [3:0] car_traffic_2,
    input  logic [3:0] car_traffic_3,
    input  logic [1:0] walk_traffic_0,
    input  logic [1:0] walk_traffic_1,
    input  logic [1:0] walk_traffic_2,
    input  logic [1:0] walk_traffic_3,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_approach,
    output logic [7:0] fault_count
);

    localparam logic [3:0] CAR_RED   = 4'b0001;
    localparam logic [3:0] CAR_YEL   = 4'b0010;
    localparam logic [3:0] CAR_GRN   = 4'b0100;
    localparam logic [3:0] CAR_LFT   = 4'b1000;
    localparam logic [3:0] CAR_GL    = 4'b1100;
    localparam logic [1:0] WALK_DONT = 2'b01;
    localparam logic [1:0] WALK_GO   = 2'b10;

    localparam int              YW    = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0]   Y_SAT = YW'(MIN_YELLOW);

    // Reject parameter values the counters cannot represent.
    generate
        if (MIN_YELLOW < 1 || FILTER_CYCLES < 1 || FILTER_CYCLES > 15) begin : g_param_check
            $error("traffic_conflict_monitor: MIN_YELLOW must be >= 1, FILTER_CYCLES in 1..15");
        end
    endgenerate

    function automatic logic car_legal(input logic [3:0] c);
        return (c == CAR_RED) || (c == CAR_YEL) || (c == CAR_GRN) ||
               (c == CAR_LFT) || (c == CAR_GL);
    endfunction

    // Green, left arrow, or both: the phases that must pass through yellow.
    function automatic logic car_moving(input logic [3:0] c);
        return (c == CAR_GRN) || (c == CAR_LFT) || (c == CAR_GL);
    endfunction

    logic [3:0] car_in  [4];
    logic [1:0] walk_in [4];

    assign car_in[0]  = car_traffic_0;
    assign car_in[1]  = car_traffic_1;
    assign car_in[2]  = car_traffic_2;
    assign car_in[3]  = car_traffic_3;
    assign walk_in[0] = walk_traffic_0;
    assign walk_in[1] = walk_traffic_1;
    assign walk_in[2] = walk_traffic_2;
    assign walk_in[3] = walk_traffic_3;

    // Sample stage. Reset values are legal lamp codes so nothing fires before
    // the first real sample arrives.
    logic [3:0]    car_cur_q  [4];
    logic [3:0]    car_prev_q [4];
    logic [1:0]    walk_cur_q [4];
    logic [YW-1:0] ycnt_q     [4];
    logic [YW-1:0] ycnt_d     [4];
    logic          sampled_q;
    logic          valid_q;

    // Capture lamps, shift cur into prev, track yellow run length behind prev.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                car_cur_q[i]  <= CAR_RED;
                car_prev_q[i] <= CAR_RED;
                walk_cur_q[i] <= WALK_DONT;
                ycnt_q[i]     <= '0;
            end
            sampled_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                car_prev_q[i] <= car_cur_q[i];
                car_cur_q[i]  <= car_in[i];
                walk_cur_q[i] <= walk_in[i];
                ycnt_q[i]     <= ycnt_d[i];
            end
            sampled_q <= 1'b1;
            // prev only holds a real sample once two samples have been taken
            valid_q   <= sampled_q;
        end
    end

    // Per-approach rule evaluation
    logic [3:0] car_go, walk_conf, inv2, car_bad, walk_bad, seq5, seq6, seq7;
    logic [1:0] axis_go;          // [0] = axis A (0/2), [1] = axis B (1/3)
    logic [1:0] axis_walk_conf;

    assign axis_go        = {car_go[1] | car_go[3], car_go[0] | car_go[2]};
    assign axis_walk_conf = {walk_conf[1] | walk_conf[3], walk_conf[0] | walk_conf[2]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_app
            // Any lit go lamp (left, green, yellow) counts as moving traffic.
            assign car_go[gi]    = |car_cur_q[gi][3:1];
            assign walk_conf[gi] = walk_cur_q[gi][1] & axis_go[1 - (gi % 2)];
            // Involved in a walk conflict: the offending walk, or a go car it conflicts with.
            assign inv2[gi]      = walk_conf[gi] | (car_go[gi] & axis_walk_conf[1 - (gi % 2)]);
            assign car_bad[gi]   = !car_legal(car_cur_q[gi]);
            assign walk_bad[gi]  = (walk_cur_q[gi] != WALK_DONT) && (walk_cur_q[gi] != WALK_GO);
            assign seq5[gi]      = valid_q && car_moving(car_prev_q[gi]) && (car_cur_q[gi] == CAR_RED);
            assign seq6[gi]      = valid_q && (car_prev_q[gi] == CAR_YEL) && (car_cur_q[gi] == CAR_RED)
                                   && (ycnt_q[gi] < Y_SAT);
            assign seq7[gi]      = valid_q && (((car_prev_q[gi] == CAR_RED) && (car_cur_q[gi] == CAR_YEL)) ||
                                               ((car_prev_q[gi] == CAR_YEL) && car_moving(car_cur_q[gi])));
            // ycnt follows cur so that, one edge later, it describes the run ending at prev.
            assign ycnt_d[gi]    = (car_cur_q[gi] != CAR_YEL) ? '0 :
                                   (ycnt_q[gi] == Y_SAT)      ? ycnt_q[gi] :
                                                                ycnt_q[gi] + 1'b1;
        end
    endgenerate

    logic [4:1] raw;
    logic [4:1] comb_hit;

    assign raw[1] = axis_go[0] & axis_go[1];
    assign raw[2] = |walk_conf;
    assign raw[3] = |car_bad;
    assign raw[4] = |walk_bad;

`ifdef MONITOR_FILTER_EN
    localparam logic [3:0] F_SAT = 4'(FILTER_CYCLES - 1);

    // Number of consecutive violating samples before the current one, per code.
    logic [3:0] persist_q [1:4];

    generate
        for (genvar gi = 1; gi <= 4; gi++) begin : g_filt
            assign comb_hit[gi] = raw[gi] && (persist_q[gi] >= F_SAT);
        end
    endgenerate

    // Persistence counters restart on any clean sample and saturate at the threshold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int c = 1; c <= 4; c++) persist_q[c] <= '0;
        end else begin
            for (int c = 1; c <= 4; c++) begin
                if (!raw[c]) begin
                    persist_q[c] <= '0;
                end else if (persist_q[c] != F_SAT) begin
                    persist_q[c] <= persist_q[c] + 4'd1;
                end
            end
        end
    end
`else
    assign comb_hit = raw;
`endif

    // Priority: lowest code, then lowest approach index in that code's mask.
    logic [7:1] hit;
    logic [3:0] who [1:7];
    logic [2:0] sel_code;
    logic [1:0] sel_app;
    logic [3:0] sel_mask;

    assign hit    = {|seq7, |seq6, |seq5, comb_hit};
    assign who[1] = car_go;
    assign who[2] = inv2;
    assign who[3] = car_bad;
    assign who[4] = walk_bad;
    assign who[5] = seq5;
    assign who[6] = seq6;
    assign who[7] = seq7;

    // Pick the winning code and its lowest involved approach.
    always_comb begin
        sel_code = '0;
        sel_mask = '0;
        sel_app  = '0;
        for (int c = 7; c >= 1; c--) begin
            if (hit[c]) begin
                sel_code = 3'(c);
                sel_mask = who[c];
            end
        end
        for (int a = 3; a >= 0; a--) begin
            if (sel_mask[a]) sel_app = 2'(a);
        end
    end

    // Fault latch and saturating violation counter
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic [1:0] app_q, app_d;
    logic [7:0] count_q, count_d;

    // Next state: clear dominates; first violation latches, each violating cycle counts.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        app_d   = app_q;
        count_d = count_q;
        if (clear) begin
            fault_d = 1'b0;
            code_d  = '0;
            app_d   = '0;
            count_d = '0;
        end else if (|hit) begin
            if (!fault_q) begin
                fault_d = 1'b1;
                code_d  = sel_code;
                app_d   = sel_app;
            end
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fault_q <= 1'b0;
            code_q  <= '0;
            app_q   <= '0;
            count_q <= '0;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
            app_q   <= app_d;
            count_q <= count_d;
        end
    end

    assign fault          = fault_q;
    assign fault_code     = code_q;
    assign fault_approach = app_q;
    assign fault_count    = count_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Testbench for traffic_conflict_monitor: directed scenarios plus randomized
// traffic checked against a history-based reference model.
`timescale 1ns/1ps
module tb_traffic_conflict_monitor;

    localparam int MIN_YELLOW    = 3;
    localparam int FILTER_CYCLES = 2;

    localparam logic [3:0] RED = 4'b0001, YEL = 4'b0010, GRN = 4'b0100, LFT = 4'b1000, GL = 4'b1100;
    localparam logic [1:0] DW  = 2'b01, WK = 2'b10;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] car_v  [4];
    logic [1:0] walk_v [4];
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] fault_approach;
    logic [7:0] fault_count;

    traffic_conflict_monitor #(
        .MIN_YELLOW    (MIN_YELLOW),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .clear          (clear),
        .car_traffic_0  (car_v[0]),
        .car_traffic_1  (car_v[1]),
        .car_traffic_2  (car_v[2]),
        .car_traffic_3  (car_v[3]),
        .walk_traffic_0 (walk_v[0]),
        .walk_traffic_1 (walk_v[1]),
        .walk_traffic_2 (walk_v[2]),
        .walk_traffic_3 (walk_v[3]),
        .fault          (fault),
        .fault_code     (fault_code),
        .fault_approach (fault_approach),
        .fault_count    (fault_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: lamp history since reset, plus expected outputs.
    logic [15:0] hist_car  [$];
    logic [7:0]  hist_walk [$];
    bit          exp_fault;
    int          exp_code, exp_app, exp_count;

    function automatic logic [3:0] lamp(logic [15:0] s, int i);
        return s[i*4 +: 4];
    endfunction

    function automatic logic [1:0] wlamp(logic [7:0] s, int i);
        return s[i*2 +: 2];
    endfunction

    function automatic bit lit_go(logic [3:0] c);
        return c[3] || c[2] || c[1];
    endfunction

    function automatic bit moving(logic [3:0] c);
        return (c == GRN) || (c == LFT) || (c == GL);
    endfunction

    // Lowest approach involved in combinational rule c (1..4) for one sample; -1 if clean.
    function automatic int comb_rule(int c, logic [15:0] s, logic [7:0] w);
        bit involved [4];
        for (int i = 0; i < 4; i++) involved[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ci;
            logic [1:0] wi;
            ci = lamp(s, i);
            wi = wlamp(w, i);
            case (c)
                1, 2: begin
                    for (int j = 0; j < 4; j++) begin
                        if (((i % 2) != (j % 2)) && lit_go(lamp(s, j))) begin
                            if ((c == 1 && lit_go(ci)) || (c == 2 && wi[1])) begin
                                involved[i] = 1'b1;
                                involved[j] = 1'b1;
                            end
                        end
                    end
                end
                3: involved[i] = !(ci == RED || ci == YEL || ci == GRN || ci == LFT || ci == GL);
                4: involved[i] = !(wi == DW || wi == WK);
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) if (involved[i]) return i;
        return -1;
    endfunction

    // Lowest approach breaking sequence rule c (5..7) on the last two samples; -1 if clean.
    function automatic int seq_rule(int c);
        int n;
        n = hist_car.size() - 1;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] p, q;
            int run;
            bit stop;
            p = lamp(hist_car[n-1], i);
            q = lamp(hist_car[n], i);
            run = 0;
            stop = 1'b0;
            for (int k = n - 1; k >= 0; k--) begin
                if (!stop && lamp(hist_car[k], i) == YEL && run < MIN_YELLOW) run++;
                else stop = 1'b1;
            end
            case (c)
                5: if (moving(p) && q == RED) return i;
                6: if (p == YEL && q == RED && run < MIN_YELLOW) return i;
                7: if ((p == RED && q == YEL) || (p == YEL && moving(q))) return i;
                default: ;
            endcase
        end
        return -1;
    endfunction

    function automatic void model_eval(output int code, output int app);
        int n;
        n = hist_car.size();
        code = 0;
        app = 0;
        if (n == 0) return;
        for (int c = 1; c <= 7; c++) begin
            int a;
            if (c <= 4) begin
                a = comb_rule(c, hist_car[n-1], hist_walk[n-1]);
`ifdef MONITOR_FILTER_EN
                if (a >= 0) begin
                    int streak;
                    bit stop;
                    streak = 0;
                    stop = 1'b0;
                    for (int k = n - 1; k >= 0; k--) begin
                        if (!stop && comb_rule(c, hist_car[k], hist_walk[k]) >= 0) streak++;
                        else stop = 1'b1;
                    end
                    if (streak < FILTER_CYCLES) a = -1;
                end
`endif
            end else begin
                a = (n >= 2) ? seq_rule(c) : -1;
            end
            if (a >= 0 && code == 0) begin
                code = c;
                app = a;
            end
        end
    endfunction

    // One clock: advance the model at the edge, then settle 1 ns for sampling.
    task automatic tick();
        int code, app;
        @(posedge clk);
        if (!rstn) begin
            exp_fault = 1'b0;
            exp_code  = 0;
            exp_app   = 0;
            exp_count = 0;
            hist_car.delete();
            hist_walk.delete();
        end else begin
            model_eval(code, app);
            if (clear) begin
                exp_fault = 1'b0;
                exp_code  = 0;
                exp_app   = 0;
                exp_count = 0;
            end else if (code != 0) begin
                if (!exp_fault) begin
                    exp_fault = 1'b1;
                    exp_code  = code;
                    exp_app   = app;
                end
                if (exp_count < 255) exp_count++;
            end
            hist_car.push_back({car_v[3], car_v[2], car_v[1], car_v[0]});
            hist_walk.push_back({walk_v[3], walk_v[2], walk_v[1], walk_v[0]});
            if (hist_car.size() > 40) begin
                void'(hist_car.pop_front());
                void'(hist_walk.pop_front());
            end
        end
        #1;
    endtask

    // cars = {c3,c2,c1,c0}, walks = {w3,w2,w1,w0}
    task automatic drive(input logic [15:0] cars, input logic [7:0] walks);
        for (int i = 0; i < 4; i++) begin
            car_v[i]  = cars[i*4 +: 4];
            walk_v[i] = walks[i*2 +: 2];
        end
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        clear = 1'b0;
        drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
        tick();
        tick();
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got f=%0b c=%0d a=%0d n=%0d want all 0",
                     fault, fault_code, fault_approach, fault_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_legal_cycle();
        do_reset();
        for (int t = 0; t < 17; t++) begin
            if (t < 10)      drive({RED, GRN, RED, GRN}, {DW, DW, DW, DW});
            else if (t < 13) drive({RED, YEL, RED, YEL}, {DW, DW, DW, DW});
            else             drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
            tick();
            n_cmp++;
            if (fault !== 1'b0 || fault_code !== 3'd0 || exp_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL legal_cycle[%0d]: got f=%0b c=%0d model f=%0b want 0/0",
                         t, fault, fault_code, exp_fault);
            end
        end
        $display("test_legal_cycle done");
    endtask

    task automatic test_axis_conflict();
        logic [13:0] want;
        do_reset();
        drive({RED, RED, GRN, GRN}, {DW, DW, DW, DW});
        tick();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL conflict_early: got f=%0b want 0", fault);
        end
        drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
        tick();
`ifdef MONITOR_FILTER_EN
        want = 14'd0;
`else
        want = {1'b1, 3'd1, 2'd0, 8'd1};
`endif
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== want) begin
            n_bad++;
            $display("FAIL conflict_latch: got f=%0b c=%0d a=%0d n=%0d want %h",
                     fault, fault_code, fault_approach, fault_count, want);
        end
        $display("test_axis_conflict done");
    endtask

    task automatic test_short_yellow();
        do_reset();
        for (int t = 0; t < 3; t++) begin drive({RED, GRN, RED, RED}, {DW, DW, DW, DW}); tick(); end
        for (int t = 0; t < 2; t++) begin drive({RED, YEL, RED, RED}, {DW, DW, DW, DW}); tick(); end
        drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
        tick();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL short_yellow_early: got f=%0b want 0", fault);
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== {1'b1, 3'd6, 2'd2, 8'd1}) begin
            n_bad++;
            $display("FAIL short_yellow: got f=%0b c=%0d a=%0d n=%0d want 1/6/2/1",
                     fault, fault_code, fault_approach, fault_count);
        end
        tick();
        tick();
        n_cmp++;
        if (fault_count !== 8'd1) begin
            n_bad++;
            $display("FAIL short_yellow_count: got %0d want 1", fault_count);
        end
        $display("test_short_yellow done");
    endtask

    task automatic test_skip_yellow();
        do_reset();
        for (int t = 0; t < 2; t++) begin drive({GRN, RED, RED, RED}, {DW, DW, DW, DW}); tick(); end
        drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
        tick();
        tick();
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== {1'b1, 3'd5, 2'd3, 8'd1}) begin
            n_bad++;
            $display("FAIL skip_yellow: got f=%0b c=%0d a=%0d n=%0d want 1/5/3/1",
                     fault, fault_code, fault_approach, fault_count);
        end
        $display("test_skip_yellow done");
    endtask

    task automatic test_simultaneous_saturation();
        do_reset();
        drive({RED, RED, 4'b0000, RED}, {DW, DW, DW, 2'b11});
        for (int t = 0; t < 300; t++) begin
            tick();
            n_cmp++;
            if ({fault, fault_code, fault_approach, fault_count} !==
                {exp_fault, 3'(exp_code), 2'(exp_app), 8'(exp_count)}) begin
                n_bad++;
                $display("FAIL simultaneous[%0d]: got f=%0b c=%0d a=%0d n=%0d want f=%0b c=%0d a=%0d n=%0d",
                         t, fault, fault_code, fault_approach, fault_count,
                         exp_fault, exp_code, exp_app, exp_count);
            end
        end
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== {1'b1, 3'd3, 2'd1, 8'd255}) begin
            n_bad++;
            $display("FAIL saturation: got f=%0b c=%0d a=%0d n=%0d want 1/3/1/255",
                     fault, fault_code, fault_approach, fault_count);
        end
        $display("test_simultaneous_saturation done");
    endtask

    task automatic test_clear();
        do_reset();
        drive({RED, RED, GRN, GRN}, {DW, DW, DW, DW});
        for (int t = 0; t < 4; t++) tick();
        n_cmp++;
        if (fault !== 1'b1 || fault_code !== 3'd1) begin
            n_bad++;
            $display("FAIL clear_setup: got f=%0b c=%0d want 1/1", fault, fault_code);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== 14'd0) begin
            n_bad++;
            $display("FAIL clear_zero: got f=%0b c=%0d a=%0d n=%0d want all 0",
                     fault, fault_code, fault_approach, fault_count);
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== {1'b1, 3'd1, 2'd0, 8'd1}) begin
            n_bad++;
            $display("FAIL clear_relatch: got f=%0b c=%0d a=%0d n=%0d want 1/1/0/1",
                     fault, fault_code, fault_approach, fault_count);
        end
        $display("test_clear done");
    endtask

    task automatic test_reset_mid_fault();
        // Fault from test_clear is still latched and the conflict still driven.
        rstn = 1'b0;
        tick();
        n_cmp++;
        if ({fault, fault_code, fault_approach, fault_count} !== 14'd0) begin
            n_bad++;
            $display("FAIL midreset_zero: got f=%0b c=%0d a=%0d n=%0d want all 0",
                     fault, fault_code, fault_approach, fault_count);
        end
        rstn = 1'b1;
        // First post-reset sample is yellow: would read as red->yellow if prev were trusted.
        for (int t = 0; t < 6; t++) begin
            if (t < 3) drive({RED, RED, RED, YEL}, {DW, DW, DW, DW});
            else       drive({RED, RED, RED, RED}, {DW, DW, DW, DW});
            tick();
            n_cmp++;
            if (fault !== 1'b0 || fault_count !== 8'd0 || exp_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_first_sample[%0d]: got f=%0b n=%0d model f=%0b want 0/0",
                         t, fault, fault_count, exp_fault);
            end
        end
        $display("test_reset_mid_fault done");
    endtask

    task automatic test_random();
        logic [3:0] legal_car [5];
        logic [1:0] legal_walk [2];
        legal_car[0] = RED; legal_car[1] = YEL; legal_car[2] = GRN; legal_car[3] = LFT; legal_car[4] = GL;
        legal_walk[0] = DW; legal_walk[1] = WK;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 99) < 88) car_v[i] = legal_car[$urandom_range(0, 4)];
                    else                            car_v[i] = 4'($urandom_range(0, 15));
                end
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 99) < 88) walk_v[i] = legal_walk[$urandom_range(0, 1)];
                    else                            walk_v[i] = 2'($urandom_range(0, 3));
                end
            end
            clear = ($urandom_range(0, 9) == 0);
            rstn  = ($urandom_range(0, 79) != 0);
            tick();
            n_cmp++;
            if ({fault, fault_code, fault_approach, fault_count} !==
                {exp_fault, 3'(exp_code), 2'(exp_app), 8'(exp_count)}) begin
                n_bad++;
                $display("FAIL random[%0d]: got f=%0b c=%0d a=%0d n=%0d want f=%0b c=%0d a=%0d n=%0d",
                         t, fault, fault_code, fault_approach, fault_count,
                         exp_fault, exp_code, exp_app, exp_count);
            end
        end
        clear = 1'b0;
        rstn  = 1'b1;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_legal_cycle();
        test_axis_conflict();
        test_short_yellow();
        test_skip_yellow();
        test_simultaneous_saturation();
        test_clear();
        test_reset_mid_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
